clock_seq_ctrl: RTL and testbench

- Sequencer for the six-stage time-of-day counter chain: sec ones, sec tens, min ones, min tens, hr ones, hr tens.
- Each stage is a counterStage-style counter with a sync enable, an active-low sync load, a load value and a terminal-count flag.
- This block generates the per-stage enables and loads for four jobs:
  - normal 1 Hz run with carry;
  - 23:59:59 to 00:00:00 rollover;
  - power-up clear;
  - a button-driven set mode for hours and minutes.
- It owns no count registers; it reads stage counts and terminal counts back.

---
 rtl/clock_pkg.sv | 44 ++++
 rtl/rise_det.sv | 21 ++
 rtl/clock_seq_ctrl.sv | 132 +++++++++++++
 tb/tb_clock_seq_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types and constants for the time-of-day counter chain sequencer.
package clock_pkg;

    localparam int unsigned NUM_STAGES = 6;
    localparam int unsigned LOAD_W     = 4;
    localparam int unsigned FIELD_W    = 2;

    // Stage index into the enable, load and terminal-count vectors
    localparam int unsigned SEC1  = 0;
    localparam int unsigned SEC10 = 1;
    localparam int unsigned MIN1  = 2;
    localparam int unsigned MIN10 = 3;
    localparam int unsigned HR1   = 4;
    localparam int unsigned HR10  = 5;

    // Terminal count of each stage in the chain
    localparam logic [LOAD_W-1:0] TC_SEC1  = 4'd9;
    localparam logic [LOAD_W-1:0] TC_SEC10 = 4'd5;
    localparam logic [LOAD_W-1:0] TC_MIN1  = 4'd9;
    localparam logic [LOAD_W-1:0] TC_MIN10 = 4'd5;
    localparam logic [LOAD_W-1:0] TC_HR1   = 4'd9;
    localparam logic [LOAD_W-1:0] TC_HR10  = 4'd2;

    localparam logic [FIELD_W-1:0] FIELD_RUN = 2'b00;
    localparam logic [FIELD_W-1:0] FIELD_HR  = 2'b01;
    localparam logic [FIELD_W-1:0] FIELD_MIN = 2'b10;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_RUN,
        ST_SET_HR,
        ST_SET_MIN
    } state_e;

    // Display blink field for a given sequencer state
    function automatic logic [FIELD_W-1:0] field_of(input state_e s);
        case (s)
            ST_SET_HR:  return FIELD_HR;
            ST_SET_MIN: return FIELD_MIN;
            default:    return FIELD_RUN;
        endcase
    endfunction

endpackage

// File: rtl/rise_det.sv
// Single-flop rising-edge detector; rise_c is high for the first cycle a level is seen high.
module rise_det (
    input  logic clk_i,
    input  logic nReset_i,
    input  logic level_i,
    output logic rise_c
);

    logic level_q;

    always_ff @(posedge clk_i or negedge nReset_i) begin
        if (!nReset_i) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level_i;
        end
    end

    assign rise_c = level_i & ~level_q;

endmodule

// File: rtl/clock_seq_ctrl.sv
// Enable/load sequencer for the six-stage time-of-day counter chain:
// 1 Hz carry run, 23:59:59 rollover, power-up clear and hour/minute set mode.
module clock_seq_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned HR_TENS_MAX = 2,
    parameter int unsigned HR_ONES_MAX = 3
) (
    input  logic                  clk_i,
    input  logic                  nReset_i,
    input  logic                  tick_i,
    input  logic                  mode_btn_i,
    input  logic                  inc_btn_i,
    input  logic [NUM_STAGES-1:0] tc_i,
    input  logic [3:0]            hr1_i,
    input  logic [1:0]            hr10_i,
    output logic [NUM_STAGES-1:0] en_o,
    output logic [NUM_STAGES-1:0] nLoad_o,
    output logic [LOAD_W-1:0]     loadVal_o,
    output logic [FIELD_W-1:0]    setField_o
);

    state_e                state, state_n;
    logic [NUM_STAGES-1:0] en_n;
    logic [NUM_STAGES-1:0] nload_n;
    logic [LOAD_W-1:0]     loadval_n;
    logic                  mode_rise_c;
    logic                  inc_rise_c;
    logic                  hr_at_max_c;
    logic                  min_sec_tc_c;
    logic                  unused_tc_top;

    rise_det u_mode_rise (
        .clk_i    (clk_i),
        .nReset_i (nReset_i),
        .level_i  (mode_btn_i),
        .rise_c   (mode_rise_c)
    );

    rise_det u_inc_rise (
        .clk_i    (clk_i),
        .nReset_i (nReset_i),
        .level_i  (inc_btn_i),
        .rise_c   (inc_rise_c)
    );

    // Hours-tens terminal count is never needed: nothing carries out of the chain
    assign unused_tc_top = tc_i[HR10];

    assign hr_at_max_c  = (hr10_i == 2'(HR_TENS_MAX)) && (hr1_i == 4'(HR_ONES_MAX));
    assign min_sec_tc_c = &tc_i[MIN10:SEC1];

    // Next state and next-cycle output pulses
    always_comb begin
        state_n   = state;
        en_n      = '0;
        nload_n   = '1;
        loadval_n = '0;

        case (state)
            ST_INIT: begin
                nload_n = '0;
                state_n = ST_RUN;
            end

            ST_RUN: begin
                if (tick_i) begin
                    en_n[SEC1]  = 1'b1;
                    en_n[SEC10] = tc_i[SEC1];
                    en_n[MIN1]  = &tc_i[SEC10:SEC1];
                    en_n[MIN10] = &tc_i[MIN1:SEC1];
                    if (hr_at_max_c && min_sec_tc_c) begin
                        nload_n[HR10:HR1] = 2'b00;
                    end else begin
                        en_n[HR1]  = min_sec_tc_c;
                        en_n[HR10] = &tc_i[HR1:SEC1];
                    end
                end
                if (mode_rise_c) begin
                    state_n = ST_SET_HR;
                end
            end

            ST_SET_HR: begin
                if (mode_rise_c) begin
                    state_n = ST_SET_MIN;
                end else if (inc_rise_c) begin
                    if (hr_at_max_c) begin
                        nload_n[HR10:HR1] = 2'b00;
                    end else if (tc_i[HR1]) begin
                        en_n[HR10:HR1] = 2'b11;
                    end else begin
                        en_n[HR1] = 1'b1;
                    end
                end
            end

            ST_SET_MIN: begin
                if (mode_rise_c) begin
                    // Leaving set mode restarts seconds from zero
                    state_n            = ST_RUN;
                    nload_n[SEC10:SEC1] = 2'b00;
                end else if (inc_rise_c) begin
                    en_n[MIN1]  = 1'b1;
                    en_n[MIN10] = tc_i[MIN1];
                end
            end

            default: begin
                state_n = ST_INIT;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk_i or negedge nReset_i) begin
        if (!nReset_i) begin
            state      <= ST_INIT;
            en_o       <= '0;
            nLoad_o    <= '1;
            loadVal_o  <= '0;
            setField_o <= FIELD_RUN;
        end else begin
            state      <= state_n;
            en_o       <= en_n;
            nLoad_o    <= nload_n;
            loadVal_o  <= loadval_n;
            setField_o <= field_of(state_n);
        end
    end

endmodule

// File: tb/tb_clock_seq_ctrl.sv
// Directed bench for clock_seq_ctrl with hand-computed expected outputs.
module tb_clock_seq_ctrl;

    logic       clk_i;
    logic       nReset_i;
    logic       tick_i;
    logic       mode_btn_i;
    logic       inc_btn_i;
    logic [5:0] tc_i;
    logic [3:0] hr1_i;
    logic [1:0] hr10_i;
    logic [5:0] en_o;
    logic [5:0] nLoad_o;
    logic [3:0] loadVal_o;
    logic [1:0] setField_o;

    int checks;
    int errors;

    clock_seq_ctrl #(
        .HR_TENS_MAX (2),
        .HR_ONES_MAX (3)
    ) dut (
        .clk_i      (clk_i),
        .nReset_i   (nReset_i),
        .tick_i     (tick_i),
        .mode_btn_i (mode_btn_i),
        .inc_btn_i  (inc_btn_i),
        .tc_i       (tc_i),
        .hr1_i      (hr1_i),
        .hr10_i     (hr10_i),
        .en_o       (en_o),
        .nLoad_o    (nLoad_o),
        .loadVal_o  (loadVal_o),
        .setField_o (setField_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Advance one clock edge; outputs are then stable for sampling and inputs may change
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        nReset_i   = 1'b0;
        tick_i     = 1'b0;
        mode_btn_i = 1'b0;
        inc_btn_i  = 1'b0;
        tc_i       = '0;
        hr1_i      = 4'd0;
        hr10_i     = 2'd1;
        step();
        step();
        checks++;
        if (en_o !== 6'b000000) begin
            errors++; $display("FAIL reset_en: got %b want %b", en_o, 6'b000000);
        end
        checks++;
        if (nLoad_o !== 6'b111111) begin
            errors++; $display("FAIL reset_nload: got %b want %b", nLoad_o, 6'b111111);
        end
        checks++;
        if (loadVal_o !== 4'd0 || setField_o !== 2'b00) begin
            errors++; $display("FAIL reset_val_field: got %h/%b want 0/00", loadVal_o, setField_o);
        end
        nReset_i = 1'b1;
        step();
        checks++;
        if (nLoad_o !== 6'b000000 || loadVal_o !== 4'd0 || en_o !== 6'b000000) begin
            errors++; $display("FAIL init_clear: got nLoad %b val %h en %b want 000000/0/000000", nLoad_o, loadVal_o, en_o);
        end
        step();
        checks++;
        if (nLoad_o !== 6'b111111 || en_o !== 6'b000000 || setField_o !== 2'b00) begin
            errors++; $display("FAIL init_done: got nLoad %b en %b field %b want 111111/000000/00", nLoad_o, en_o, setField_o);
        end
    endtask

    task automatic test_run_carry();
        hr10_i = 2'd1;
        hr1_i  = 4'd2;
        tc_i   = 6'b000000;
        tick_i = 1'b1;
        step();
        tick_i = 1'b0;
        checks++;
        if (en_o !== 6'b000001 || nLoad_o !== 6'b111111) begin
            errors++; $display("FAIL run_plain_tick: got en %b nLoad %b want 000001/111111", en_o, nLoad_o);
        end
        step();
        checks++;
        if (en_o !== 6'b000000) begin
            errors++; $display("FAIL run_pulse_width: got en %b want 000000", en_o);
        end
        tc_i   = 6'b001111;
        tick_i = 1'b1;
        step();
        tick_i = 1'b0;
        checks++;
        if (en_o !== 6'b011111 || nLoad_o !== 6'b111111) begin
            errors++; $display("FAIL run_carry_hr1: got en %b nLoad %b want 011111/111111", en_o, nLoad_o);
        end
        tc_i   = 6'b011111;
        hr10_i = 2'd0;
        hr1_i  = 4'd9;
        tick_i = 1'b1;
        step();
        tick_i = 1'b0;
        checks++;
        if (en_o !== 6'b111111 || nLoad_o !== 6'b111111) begin
            errors++; $display("FAIL run_carry_hr10: got en %b nLoad %b want 111111/111111", en_o, nLoad_o);
        end
        tc_i = 6'b000000;
        step();
    endtask

    task automatic test_rollover();
        tc_i   = 6'b001111;
        hr10_i = 2'd2;
        hr1_i  = 4'd3;
        tick_i = 1'b1;
        step();
        tick_i = 1'b0;
        checks++;
        if (en_o !== 6'b001111 || nLoad_o !== 6'b001111 || loadVal_o !== 4'd0) begin
            errors++; $display("FAIL rollover: got en %b nLoad %b val %h want 001111/001111/0", en_o, nLoad_o, loadVal_o);
        end
        step();
        checks++;
        if (nLoad_o !== 6'b111111 || en_o !== 6'b000000) begin
            errors++; $display("FAIL rollover_idle: got en %b nLoad %b want 000000/111111", en_o, nLoad_o);
        end
        // At 23 but minutes not at 59: no rollover, plain seconds count
        tc_i   = 6'b000111;
        tick_i = 1'b1;
        step();
        tick_i = 1'b0;
        checks++;
        if (en_o !== 6'b001111 || nLoad_o !== 6'b111111) begin
            errors++; $display("FAIL rollover_partial: got en %b nLoad %b want 001111/111111", en_o, nLoad_o);
        end
        tc_i = 6'b000000;
        step();
    endtask

    task automatic test_set_hr();
        mode_btn_i = 1'b1;
        step();
        mode_btn_i = 1'b0;
        checks++;
        if (setField_o !== 2'b01 || en_o !== 6'b000000) begin
            errors++; $display("FAIL enter_set_hr: got field %b en %b want 01/000000", setField_o, en_o);
        end
        hr10_i    = 2'd2;
        hr1_i     = 4'd2;
        tc_i      = 6'b000000;
        inc_btn_i = 1'b1;
        step();
        inc_btn_i = 1'b0;
        checks++;
        if (en_o !== 6'b010000 || nLoad_o !== 6'b111111) begin
            errors++; $display("FAIL set_hr_inc22: got en %b nLoad %b want 010000/111111", en_o, nLoad_o);
        end
        step();
        hr1_i     = 4'd3;
        inc_btn_i = 1'b1;
        step();
        inc_btn_i = 1'b0;
        checks++;
        if (nLoad_o !== 6'b001111 || en_o !== 6'b000000 || loadVal_o !== 4'd0) begin
            errors++; $display("FAIL set_hr_wrap23: got nLoad %b en %b val %h want 001111/000000/0", nLoad_o, en_o, loadVal_o);
        end
        step();
        hr10_i    = 2'd0;
        hr1_i     = 4'd9;
        tc_i      = 6'b010000;
        inc_btn_i = 1'b1;
        step();
        inc_btn_i = 1'b0;
        checks++;
        if (en_o !== 6'b110000 || nLoad_o !== 6'b111111) begin
            errors++; $display("FAIL set_hr_inc09: got en %b nLoad %b want 110000/111111", en_o, nLoad_o);
        end
        tc_i   = 6'b001111;
        tick_i = 1'b1;
        step();
        tick_i = 1'b0;
        checks++;
        if (en_o !== 6'b000000 || setField_o !== 2'b01) begin
            errors++; $display("FAIL set_hr_tick_frozen: got en %b field %b want 000000/01", en_o, setField_o);
        end
        tc_i = 6'b000000;
        step();
    endtask

    task automatic test_set_min();
        mode_btn_i = 1'b1;
        step();
        mode_btn_i = 1'b0;
        checks++;
        if (setField_o !== 2'b10 || nLoad_o !== 6'b111111) begin
            errors++; $display("FAIL enter_set_min: got field %b nLoad %b want 10/111111", setField_o, nLoad_o);
        end
        tc_i      = 6'b000100;
        inc_btn_i = 1'b1;
        step();
        inc_btn_i = 1'b0;
        checks++;
        if (en_o !== 6'b001100) begin
            errors++; $display("FAIL set_min_carry: got en %b want 001100", en_o);
        end
        step();
        tc_i      = 6'b011000;
        inc_btn_i = 1'b1;
        step();
        inc_btn_i = 1'b0;
        checks++;
        if (en_o !== 6'b000100) begin
            errors++; $display("FAIL set_min_no_hr_carry: got en %b want 000100", en_o);
        end
        tc_i       = 6'b000000;
        mode_btn_i = 1'b1;
        step();
        mode_btn_i = 1'b0;
        checks++;
        if (setField_o !== 2'b00 || nLoad_o !== 6'b111100 || loadVal_o !== 4'd0 || en_o !== 6'b000000) begin
            errors++; $display("FAIL exit_set_min: got field %b nLoad %b val %h en %b want 00/111100/0/000000", setField_o, nLoad_o, loadVal_o, en_o);
        end
        step();
        checks++;
        if (nLoad_o !== 6'b111111) begin
            errors++; $display("FAIL exit_load_width: got nLoad %b want 111111", nLoad_o);
        end
    endtask

    task automatic test_back_to_back();
        int pulses;
        // Mode and inc together in RUN: enter SET_HR, no pulse
        mode_btn_i = 1'b1;
        inc_btn_i  = 1'b1;
        step();
        mode_btn_i = 1'b0;
        inc_btn_i  = 1'b0;
        checks++;
        if (setField_o !== 2'b01 || en_o !== 6'b000000) begin
            errors++; $display("FAIL run_mode_inc: got field %b en %b want 01/000000", setField_o, en_o);
        end
        step();
        hr10_i     = 2'd1;
        hr1_i      = 4'd0;
        mode_btn_i = 1'b1;
        inc_btn_i  = 1'b1;
        step();
        mode_btn_i = 1'b0;
        checks++;
        if (setField_o !== 2'b10 || en_o !== 6'b000000) begin
            errors++; $display("FAIL set_hr_mode_wins: got field %b en %b want 10/000000", setField_o, en_o);
        end
        // inc stays high from the dropped edge: must not produce a late increment
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (en_o !== 6'b000000) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++; $display("FAIL dropped_inc_held: got %0d pulses want 0", pulses);
        end
        inc_btn_i = 1'b0;
        step();
        inc_btn_i = 1'b1;
        pulses    = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (en_o === 6'b000100) pulses++;
            else if (en_o !== 6'b000000) pulses += 100;
        end
        inc_btn_i = 1'b0;
        checks++;
        if (pulses !== 1) begin
            errors++; $display("FAIL inc_held_once: got %0d (x100 = bad pattern) want 1", pulses);
        end
        mode_btn_i = 1'b1;
        step();
        mode_btn_i = 1'b0;
        step();
        // Tick coinciding with mode in RUN is still counted
        tc_i       = 6'b000001;
        tick_i     = 1'b1;
        mode_btn_i = 1'b1;
        step();
        tick_i     = 1'b0;
        mode_btn_i = 1'b0;
        checks++;
        if (en_o !== 6'b000011 || setField_o !== 2'b01) begin
            errors++; $display("FAIL tick_with_mode: got en %b field %b want 000011/01", en_o, setField_o);
        end
        tc_i = 6'b000000;
        step();
    endtask

    task automatic test_reset_mid();
        // Currently in SET_HR; request a load, then reset before it can take effect
        hr10_i    = 2'd2;
        hr1_i     = 4'd3;
        inc_btn_i = 1'b1;
        #2;
        nReset_i  = 1'b0;
        #1;
        checks++;
        if (nLoad_o !== 6'b111111 || en_o !== 6'b000000 || setField_o !== 2'b00) begin
            errors++; $display("FAIL async_reset: got nLoad %b en %b field %b want 111111/000000/00", nLoad_o, en_o, setField_o);
        end
        step();
        checks++;
        if (nLoad_o !== 6'b111111) begin
            errors++; $display("FAIL reset_held_load: got nLoad %b want 111111", nLoad_o);
        end
        inc_btn_i = 1'b0;
        nReset_i  = 1'b1;
        step();
        checks++;
        if (nLoad_o !== 6'b000000 || setField_o !== 2'b00) begin
            errors++; $display("FAIL reinit_clear: got nLoad %b field %b want 000000/00", nLoad_o, setField_o);
        end
        step();
        tc_i   = 6'b000011;
        hr10_i = 2'd0;
        tick_i = 1'b1;
        step();
        tick_i = 1'b0;
        checks++;
        if (en_o !== 6'b000111 || nLoad_o !== 6'b111111) begin
            errors++; $display("FAIL run_after_reset: got en %b nLoad %b want 000111/111111", en_o, nLoad_o);
        end
        tc_i = 6'b000000;
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_run_carry();
        test_rollover();
        test_set_hr();
        test_set_min();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
